// File: rtl/sniffer_pkg.sv
// Shared types and constants for the sniffer input-stream arbitration logic.
package sniffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PKT   = 2'd1,
    ST_FLUSH = 2'd2
  } arb_state_t;

  localparam int unsigned DEFAULT_MAX_BEATS = 1600;
  localparam int unsigned DEFAULT_ERRWIDTH  = 6;
  localparam int unsigned TRUNC_ERR_BIT     = DEFAULT_ERRWIDTH - 1;

  // Truncation is flagged on the MSB of whatever error field width is in use.
  function automatic int unsigned trunc_err_bit(input int unsigned errwidth);
    return errwidth - 1;
  endfunction

endpackage

// File: rtl/sniffer_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr, modulo N.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic        found;
  int unsigned j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/sniffer_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding the single sniffer input stream,
// with rule-update hold-off, oversize truncation and out-of-packet beat flushing.
module sniffer_stream_arbiter
  import sniffer_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned DATAWIDTH  = 32,
  parameter int unsigned EMPTYWIDTH = 2,
  parameter int unsigned ERRWIDTH   = DEFAULT_ERRWIDTH,
  parameter int unsigned MAX_BEATS  = DEFAULT_MAX_BEATS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_SRC*DATAWIDTH-1:0]   src_data,
  input  logic [NUM_SRC-1:0]             src_valid,
  input  logic [NUM_SRC-1:0]             src_sop,
  input  logic [NUM_SRC-1:0]             src_eop,
  input  logic [NUM_SRC*EMPTYWIDTH-1:0]  src_empty,
  input  logic [NUM_SRC*ERRWIDTH-1:0]    src_error,
  output logic [NUM_SRC-1:0]             src_ready,
  output logic [DATAWIDTH-1:0]           snf_data,
  output logic                           snf_valid,
  output logic                           snf_sop,
  output logic                           snf_eop,
  output logic [EMPTYWIDTH-1:0]          snf_empty,
  output logic [ERRWIDTH-1:0]            snf_error,
  input  logic                           snf_ready,
  input  logic [NUM_SRC-1:0]             src_mask,
  input  logic                           run_enable,
  input  logic                           rule_busy,
  output logic                           grant_valid,
  output logic [$clog2(NUM_SRC)-1:0]     grant_id,
  output logic [31:0]                    pkt_count,
  output logic [31:0]                    drop_count,
  output logic [15:0]                    trunc_count
);

  localparam int unsigned IW   = $clog2(NUM_SRC);
  localparam int unsigned BW   = $clog2(MAX_BEATS + 1);
  localparam int unsigned TBIT = trunc_err_bit(ERRWIDTH);

  arb_state_t            state;
  logic [IW-1:0]         rr_ptr;
  logic [BW-1:0]         beat_cnt;
  logic [NUM_SRC-1:0]    req;
  logic [NUM_SRC-1:0]    drop_vec;
  logic [NUM_SRC-1:0]    pick_onehot;
  logic [IW-1:0]         pick_idx;
  logic                  pick_any;
  logic [31:0]           drop_inc;
  logic [NUM_SRC-1:0]    g_onehot;
  logic [DATAWIDTH-1:0]  g_data;
  logic [EMPTYWIDTH-1:0] g_empty;
  logic [ERRWIDTH-1:0]   g_error;
  logic                  g_valid;
  logic                  g_sop;
  logic                  g_eop;
  logic                  at_limit;
  logic                  trunc_beat;
  logic                  xfer;
  logic [IW-1:0]         next_ptr;

  assign req      = src_valid & src_sop & src_mask;
  assign drop_vec = src_valid & ~src_sop & src_mask;
  assign pick_any = |pick_onehot;

  rr_pick #(.N(NUM_SRC), .IW(IW)) u_rr_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (pick_onehot),
    .idx   (pick_idx)
  );

  always_comb begin
    g_onehot = '0;
    g_data   = '0;
    g_empty  = '0;
    g_error  = '0;
    g_valid  = 1'b0;
    g_sop    = 1'b0;
    g_eop    = 1'b0;
    drop_inc = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      drop_inc = drop_inc + 32'(drop_vec[i]);
      if (grant_id == IW'(i)) begin
        g_onehot[i] = 1'b1;
        g_data      = src_data[i*DATAWIDTH +: DATAWIDTH];
        g_empty     = src_empty[i*EMPTYWIDTH +: EMPTYWIDTH];
        g_error     = src_error[i*ERRWIDTH +: ERRWIDTH];
        g_valid     = src_valid[i];
        g_sop       = src_sop[i];
        g_eop       = src_eop[i];
      end
    end
  end

  // The MAX_BEATS-th beat is closed off as eop unless the source already ends there.
  assign at_limit   = (beat_cnt == BW'(MAX_BEATS - 1));
  assign trunc_beat = at_limit & ~g_eop;
  assign xfer       = (state == ST_PKT) & g_valid & snf_ready;
  assign next_ptr   = (grant_id == IW'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    src_ready = '0;
    snf_valid = 1'b0;
    snf_sop   = 1'b0;
    snf_eop   = 1'b0;
    snf_data  = '0;
    snf_empty = '0;
    snf_error = '0;
    unique case (state)
      ST_IDLE:  src_ready = drop_vec;
      ST_PKT: begin
        src_ready       = g_onehot & {NUM_SRC{snf_ready}};
        snf_valid       = g_valid;
        snf_sop         = g_sop;
        snf_eop         = g_eop | trunc_beat;
        snf_data        = g_data;
        snf_empty       = g_empty;
        snf_error       = g_error;
        snf_error[TBIT] = g_error[TBIT] | trunc_beat;
      end
      ST_FLUSH: src_ready = g_onehot;
      default:  src_ready = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      beat_cnt    <= '0;
      pkt_count   <= '0;
      drop_count  <= '0;
      trunc_count <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          drop_count <= drop_count + drop_inc;
          if (run_enable && !rule_busy && pick_any) begin
            grant_id    <= pick_idx;
            grant_valid <= 1'b1;
            beat_cnt    <= '0;
            state       <= ST_PKT;
          end
        end
        ST_PKT: begin
          if (xfer) begin
            if (g_eop) begin
              pkt_count   <= pkt_count + 32'd1;
              rr_ptr      <= next_ptr;
              grant_valid <= 1'b0;
              state       <= ST_IDLE;
            end else if (at_limit) begin
              pkt_count   <= pkt_count + 32'd1;
              trunc_count <= (trunc_count == 16'hFFFF) ? trunc_count : trunc_count + 16'd1;
              state       <= ST_FLUSH;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          if (g_valid && g_eop) begin
            rr_ptr      <= next_ptr;
            grant_valid <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sniffer_stream_arbiter.sv
// Directed bench for sniffer_stream_arbiter: per-scenario tasks with hand-computed cycle tables.
module tb_sniffer_stream_arbiter;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int EW = 2;
  localparam int RW = 6;
  localparam int MB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [NS*DW-1:0]  src_data;
  logic [NS-1:0]     src_valid, src_sop, src_eop, src_ready, src_mask;
  logic [NS*EW-1:0]  src_empty;
  logic [NS*RW-1:0]  src_error;
  logic [DW-1:0]     snf_data;
  logic              snf_valid, snf_sop, snf_eop, snf_ready;
  logic [EW-1:0]     snf_empty;
  logic [RW-1:0]     snf_error;
  logic              run_enable, rule_busy, grant_valid;
  logic [1:0]        grant_id;
  logic [31:0]       pkt_count, drop_count;
  logic [15:0]       trunc_count;

  int checks = 0;
  int errors = 0;

  bit reset_next, ready_next, busy_next;
  bit active [NS];
  int idx    [NS];
  int len    [NS];
  int nosop  [NS];

  sniffer_stream_arbiter #(
    .NUM_SRC(NS), .DATAWIDTH(DW), .EMPTYWIDTH(EW), .ERRWIDTH(RW), .MAX_BEATS(MB)
  ) dut (
    .clk(clk), .reset(reset),
    .src_data(src_data), .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop),
    .src_empty(src_empty), .src_error(src_error), .src_ready(src_ready),
    .snf_data(snf_data), .snf_valid(snf_valid), .snf_sop(snf_sop), .snf_eop(snf_eop),
    .snf_empty(snf_empty), .snf_error(snf_error), .snf_ready(snf_ready),
    .src_mask(src_mask), .run_enable(run_enable), .rule_busy(rule_busy),
    .grant_valid(grant_valid), .grant_id(grant_id),
    .pkt_count(pkt_count), .drop_count(drop_count), .trunc_count(trunc_count)
  );

  // Expected sink beat: {valid, sop, eop, empty, error, data}; source s beat i carries data s*256+i, empty s.
  function automatic logic [42:0] bt(input int s, input int i, input bit sop, input bit eop, input bit trunc);
    logic [5:0] e;
    e = trunc ? 6'b100000 : 6'b000000;
    return {1'b1, sop, eop, 2'(s), e, 32'(s*256 + i)};
  endfunction

  function automatic logic [42:0] obs();
    return {snf_valid, snf_sop, snf_eop, snf_empty, snf_error, snf_data};
  endfunction

  task automatic drive_srcs();
    for (int s = 0; s < NS; s++) begin
      src_data[s*DW +: DW]  = '0;
      src_empty[s*EW +: EW] = '0;
      src_error[s*RW +: RW] = '0;
      src_valid[s] = 1'b0;
      src_sop[s]   = 1'b0;
      src_eop[s]   = 1'b0;
      if (active[s] && idx[s] < len[s]) begin
        src_valid[s] = 1'b1;
        src_sop[s]   = (idx[s] == 0);
        src_eop[s]   = (idx[s] == len[s] - 1);
        src_data[s*DW +: DW]  = 32'(s*256 + idx[s]);
        src_empty[s*EW +: EW] = 2'(s);
      end else if (nosop[s] > 0) begin
        src_valid[s] = 1'b1;
        src_data[s*DW +: DW] = 32'(s*256 + 128);
      end
    end
  endtask

  // Called at a negedge: commits handshakes of the current cycle, drives the next, ends at its negedge.
  task automatic tick();
    logic [NS-1:0] x;
    bit was_rst;
    x = src_valid & src_ready;
    was_rst = reset;
    @(posedge clk);
    #1;
    for (int s = 0; s < NS; s++) begin
      if (was_rst) begin
        idx[s]   = 0;
        nosop[s] = 0;
      end else if (x[s]) begin
        if (active[s] && idx[s] < len[s]) begin
          idx[s]++;
          if (idx[s] == len[s]) active[s] = 1'b0;
        end else if (nosop[s] > 0) begin
          nosop[s]--;
        end
      end
    end
    reset      = reset_next;
    snf_ready  = ready_next;
    rule_busy  = busy_next;
    drive_srcs();
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick();
    checks++; if (obs() !== 43'h0) begin errors++; $display("FAIL reset_sink got %h want 0", obs()); end
    checks++; if (src_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got %b want 0000", src_ready); end
    checks++; if (grant_valid !== 1'b0 || grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got %b/%0d want 0/0", grant_valid, grant_id); end
    checks++; if ({pkt_count, drop_count, trunc_count} !== 80'h0) begin errors++; $display("FAIL reset_counters got %0d %0d %0d want 0 0 0", pkt_count, drop_count, trunc_count); end
    reset_next = 1'b0;
    tick();
    checks++; if (obs() !== 43'h0 || grant_valid !== 1'b0) begin errors++; $display("FAIL idle_after_reset got %h/%b want 0/0", obs(), grant_valid); end
  endtask

  task automatic test_round_robin();
    logic [42:0] exp [9];
    exp = '{43'h0, bt(0,0,1,0,0), bt(0,1,0,0,0), bt(0,2,0,1,0), 43'h0,
            bt(2,0,1,0,0), bt(2,1,0,0,0), bt(2,2,0,1,0), 43'h0};
    active[0] = 1'b1; len[0] = 3; idx[0] = 0;
    active[2] = 1'b1; len[2] = 3; idx[2] = 0;
    for (int c = 0; c < 9; c++) begin
      tick();
      checks++; if (obs() !== exp[c]) begin errors++; $display("FAIL rr_beat c%0d got %h want %h", c, obs(), exp[c]); end
      checks++; if (grant_valid !== exp[c][42]) begin errors++; $display("FAIL rr_grant_valid c%0d got %b want %b", c, grant_valid, exp[c][42]); end
      if (c == 1 || c == 5) begin
        checks++; if (grant_id !== ((c == 1) ? 2'd0 : 2'd2)) begin errors++; $display("FAIL rr_grant_id c%0d got %0d want %0d", c, grant_id, (c == 1) ? 0 : 2); end
      end
    end
    checks++; if (pkt_count !== 32'd2) begin errors++; $display("FAIL rr_pkt_count got %0d want 2", pkt_count); end
  endtask

  task automatic test_backpressure();
    logic [42:0] exp [7];
    bit          rdy [7];
    exp = '{43'h0, bt(1,0,1,0,0), bt(1,1,0,0,0), bt(1,1,0,0,0), bt(1,2,0,1,0), bt(1,2,0,1,0), 43'h0};
    rdy = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    active[1] = 1'b1; len[1] = 3; idx[1] = 0;
    for (int c = 0; c < 7; c++) begin
      ready_next = rdy[c];
      tick();
      checks++; if (obs() !== exp[c]) begin errors++; $display("FAIL bp_beat c%0d got %h want %h", c, obs(), exp[c]); end
      checks++;
      if (src_ready !== ((c >= 1 && c <= 5 && rdy[c]) ? 4'b0010 : 4'b0000)) begin
        errors++; $display("FAIL bp_ready c%0d got %b want %b", c, src_ready, (c >= 1 && c <= 5 && rdy[c]) ? 4'b0010 : 4'b0000);
      end
    end
    ready_next = 1'b1;
    checks++; if (pkt_count !== 32'd3) begin errors++; $display("FAIL bp_pkt_count got %0d want 3", pkt_count); end
  endtask

  task automatic test_truncate();
    logic [42:0] exp [9];
    exp = '{43'h0, bt(3,0,1,0,0), bt(3,1,0,0,0), bt(3,2,0,0,0), bt(3,3,0,1,1),
            43'h0, 43'h0, 43'h0, 43'h0};
    active[3] = 1'b1; len[3] = 7; idx[3] = 0;
    for (int c = 0; c < 9; c++) begin
      tick();
      checks++; if (obs() !== exp[c]) begin errors++; $display("FAIL trunc_beat c%0d got %h want %h", c, obs(), exp[c]); end
      checks++;
      if (src_ready !== ((c >= 1 && c <= 7) ? 4'b1000 : 4'b0000) || grant_valid !== (c >= 1 && c <= 7)) begin
        errors++; $display("FAIL trunc_ready_grant c%0d got %b/%b want %b/%b", c, src_ready, grant_valid,
                           (c >= 1 && c <= 7) ? 4'b1000 : 4'b0000, (c >= 1 && c <= 7));
      end
    end
    checks++; if (trunc_count !== 16'd1) begin errors++; $display("FAIL trunc_count got %0d want 1", trunc_count); end
    checks++; if (pkt_count !== 32'd4) begin errors++; $display("FAIL trunc_pkt_count got %0d want 4", pkt_count); end
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL trunc_flush_not_dropped got %0d want 0", drop_count); end
  endtask

  task automatic test_drop();
    nosop[0] = 2;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (src_ready !== ((c < 2) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL drop_ready c%0d got %b want %b", c, src_ready, (c < 2) ? 4'b0001 : 4'b0000); end
      checks++; if (drop_count !== 32'(c)) begin errors++; $display("FAIL drop_count c%0d got %0d want %0d", c, drop_count, c); end
      checks++; if (grant_valid !== 1'b0 || obs() !== 43'h0) begin errors++; $display("FAIL drop_no_grant c%0d got %b/%h want 0/0", c, grant_valid, obs()); end
    end
  endtask

  task automatic test_rule_busy();
    busy_next = 1'b1;
    active[1] = 1'b1; len[1] = 3; idx[1] = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (grant_valid !== 1'b0 || obs() !== 43'h0 || src_ready !== 4'b0) begin
        errors++; $display("FAIL busy_hold c%0d got %b/%h/%b want 0/0/0000", c, grant_valid, obs(), src_ready);
      end
    end
    busy_next = 1'b0;
    tick();
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL busy_release_bubble got %b want 0", grant_valid); end
    busy_next = 1'b1;
    tick();
    checks++; if (obs() !== bt(1,0,1,0,0) || grant_id !== 2'd1) begin errors++; $display("FAIL busy_grant got %h/%0d want %h/1", obs(), grant_id, bt(1,0,1,0,0)); end
    tick();
    checks++; if (obs() !== bt(1,1,0,0,0)) begin errors++; $display("FAIL busy_mid got %h want %h", obs(), bt(1,1,0,0,0)); end
    tick();
    checks++; if (obs() !== bt(1,2,0,1,0)) begin errors++; $display("FAIL busy_last got %h want %h", obs(), bt(1,2,0,1,0)); end
    tick();
    checks++; if (pkt_count !== 32'd5 || grant_valid !== 1'b0) begin errors++; $display("FAIL busy_done got %0d/%b want 5/0", pkt_count, grant_valid); end
    busy_next = 1'b0;
  endtask

  task automatic test_reset_mid_packet();
    active[1] = 1'b1; len[1] = 5; idx[1] = 0;
    tick();
    tick();
    checks++; if (obs() !== bt(1,0,1,0,0)) begin errors++; $display("FAIL rst_beat1 got %h want %h", obs(), bt(1,0,1,0,0)); end
    reset_next = 1'b1;
    tick();
    checks++; if (obs() !== bt(1,1,0,0,0)) begin errors++; $display("FAIL rst_beat2 got %h want %h", obs(), bt(1,1,0,0,0)); end
    reset_next = 1'b0;
    tick();
    checks++; if (obs() !== 43'h0 || src_ready !== 4'b0) begin errors++; $display("FAIL rst_sink got %h/%b want 0/0000", obs(), src_ready); end
    checks++; if (grant_valid !== 1'b0 || grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant got %b/%0d want 0/0", grant_valid, grant_id); end
    checks++; if ({pkt_count, drop_count, trunc_count} !== 80'h0) begin errors++; $display("FAIL rst_counters got %0d %0d %0d want 0 0 0", pkt_count, drop_count, trunc_count); end
    tick();
    checks++; if (obs() !== bt(1,0,1,0,0) || grant_id !== 2'd1 || grant_valid !== 1'b1) begin
      errors++; $display("FAIL rst_regrant got %h/%0d/%b want %h/1/1", obs(), grant_id, grant_valid, bt(1,0,1,0,0));
    end
    tick();
    checks++; if (obs() !== bt(1,1,0,0,0)) begin errors++; $display("FAIL rst_resume got %h want %h", obs(), bt(1,1,0,0,0)); end
    reset_next = 1'b1;
    active[1] = 1'b0;
    tick();
    reset_next = 1'b0;
    tick();
  endtask

  initial begin
    for (int s = 0; s < NS; s++) begin
      active[s] = 1'b0; idx[s] = 0; len[s] = 0; nosop[s] = 0;
    end
    reset      = 1'b1;
    reset_next = 1'b1;
    ready_next = 1'b1;
    busy_next  = 1'b0;
    snf_ready  = 1'b1;
    rule_busy  = 1'b0;
    run_enable = 1'b1;
    src_mask   = 4'hF;
    drive_srcs();
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_backpressure();
    test_truncate();
    test_drop();
    test_rule_busy();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
